// File: rtl/cpu_run_monitor.sv
// Run controller for the CPU: sequences its reset, counts cycles and stops it on halt, PC stall or timeout.
// Optional macro CPU_RUN_MONITOR_HALT_PC_EN adds the halt_pc output (pc captured when RUN exits).
module cpu_run_monitor #(
  parameter int PC_W         = 16,
  parameter int CNT_W        = 32,
  parameter int RST_CYCLES   = 2,
  parameter int DRAIN_CYCLES = 1,
  parameter int STALL_LIMIT  = 64,
  parameter int TIMEOUT      = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hlt,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_rst_n,
  output logic             running,
  output logic             done,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] cycles
`ifdef CPU_RUN_MONITOR_HALT_PC_EN
  ,
  output logic [PC_W-1:0]  halt_pc
`endif
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 2);
  localparam int SW = $clog2(STALL_LIMIT);

  typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [SW-1:0]    stall_q, stall_d;
  logic [PC_W-1:0]  pc_prev_q, pc_prev_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [1:0]       status_q, status_d;
  logic             cpu_rst_n_q, cpu_rst_n_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
`ifdef CPU_RUN_MONITOR_HALT_PC_EN
  logic [PC_W-1:0]  halt_pc_q, halt_pc_d;
`endif

  logic [CNT_W-1:0] cyc_inc;
  logic             pc_same, first_run, stall_hit, to_done;

  always_comb begin
    state_d     = state_q;
    rcnt_d      = rcnt_q;
    dcnt_d      = dcnt_q;
    stall_d     = stall_q;
    pc_prev_d   = pc_prev_q;
    cycles_d    = cycles_q;
    status_d    = status_q;
    cpu_rst_n_d = cpu_rst_n_q;
    running_d   = running_q;
    done_d      = done_q;
`ifdef CPU_RUN_MONITOR_HALT_PC_EN
    halt_pc_d   = halt_pc_q;
`endif
    cyc_inc   = (&cycles_q) ? cycles_q : cycles_q + 1'b1;
    pc_same   = (pc == pc_prev_q);
    // cycles is cleared on start, so zero in RUN marks the first RUN cycle
    first_run = (cycles_q == '0);
    stall_hit = !first_run && pc_same && (stall_q == SW'(STALL_LIMIT - 1));
    to_done   = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: if (start) begin
        state_d     = S_RESET;
        status_d    = 2'b00;
        cycles_d    = '0;
        rcnt_d      = RW'(RST_CYCLES - 1);
        cpu_rst_n_d = 1'b0;
        running_d   = 1'b0;
        done_d      = 1'b0;
`ifdef CPU_RUN_MONITOR_HALT_PC_EN
        halt_pc_d   = '0;
`endif
      end
      S_RESET: begin
        if (rcnt_q == '0) begin
          state_d     = S_RUN;
          cpu_rst_n_d = 1'b1;
          running_d   = 1'b1;
        end else begin
          rcnt_d = rcnt_q - 1'b1;
        end
      end
      S_RUN: begin
        cycles_d  = cyc_inc;
        pc_prev_d = pc;
        if (first_run || !pc_same) stall_d = '0;
        else if (!(&stall_q))      stall_d = stall_q + 1'b1;
        // exit priority: halt, then stall, then timeout
        if (hlt) begin
          status_d = 2'b01;
          if (DRAIN_CYCLES > 0) begin
            state_d = S_DRAIN;
            dcnt_d  = DW'(DRAIN_CYCLES > 0 ? DRAIN_CYCLES - 1 : 0);
          end else begin
            to_done = 1'b1;
          end
        end else if (stall_hit) begin
          status_d = 2'b11;
          to_done  = 1'b1;
        end else if (cyc_inc == CNT_W'(TIMEOUT)) begin
          status_d = 2'b10;
          to_done  = 1'b1;
        end
      end
      S_DRAIN: begin
        cycles_d = cyc_inc;
        if (dcnt_q == '0) to_done = 1'b1;
        else              dcnt_d  = dcnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (to_done) begin
      state_d     = S_DONE;
      cpu_rst_n_d = 1'b0;
      running_d   = 1'b0;
      done_d      = 1'b1;
    end
`ifdef CPU_RUN_MONITOR_HALT_PC_EN
    if (state_q == S_RUN && state_d != S_RUN) halt_pc_d = pc;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rcnt_q      <= '0;
      dcnt_q      <= '0;
      stall_q     <= '0;
      pc_prev_q   <= '0;
      cycles_q    <= '0;
      status_q    <= 2'b00;
      cpu_rst_n_q <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
`ifdef CPU_RUN_MONITOR_HALT_PC_EN
      halt_pc_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      dcnt_q      <= dcnt_d;
      stall_q     <= stall_d;
      pc_prev_q   <= pc_prev_d;
      cycles_q    <= cycles_d;
      status_q    <= status_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      running_q   <= running_d;
      done_q      <= done_d;
`ifdef CPU_RUN_MONITOR_HALT_PC_EN
      halt_pc_q   <= halt_pc_d;
`endif
    end
  end

  assign cpu_rst_n = cpu_rst_n_q;
  assign running   = running_q;
  assign done      = done_q;
  assign status    = status_q;
  assign cycles    = cycles_q;
`ifdef CPU_RUN_MONITOR_HALT_PC_EN
  assign halt_pc   = halt_pc_q;
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Randomized bench for cpu_run_monitor; each run's outcome is predicted from the pc/hlt stimulus
// it is given (first halt, first run of STALL_LIMIT repeated pc compares, or TIMEOUT).
module tb_cpu_run_monitor;
  localparam int PC_W = 16, CNT_W = 32, RST_CYCLES = 2, DRAIN_CYCLES = 1;
  localparam int STALL_LIMIT = 4, TIMEOUT = 20;

  logic clk = 1'b0;
  logic rst, start, hlt;
  logic [PC_W-1:0]  pc;
  logic             cpu_rst_n, running, done;
  logic [1:0]       status;
  logic [CNT_W-1:0] cycles;
`ifdef CPU_RUN_MONITOR_HALT_PC_EN
  logic [PC_W-1:0]  halt_pc;
`endif

  cpu_run_monitor #(
    .PC_W(PC_W), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES),
    .STALL_LIMIT(STALL_LIMIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .hlt(hlt), .pc(pc),
    .cpu_rst_n(cpu_rst_n), .running(running), .done(done), .status(status), .cycles(cycles)
`ifdef CPU_RUN_MONITOR_HALT_PC_EN
    , .halt_pc(halt_pc)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [PC_W-1:0] pcv [1:TIMEOUT];
  logic            hv  [1:TIMEOUT];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input bit e_rstn, input bit e_run, input bit e_done,
                         input logic [1:0] e_st, input int e_cyc);
    chk({tag, "/cpu_rst_n"}, cpu_rst_n, e_rstn);
    chk({tag, "/running"},   running,   e_run);
    chk({tag, "/done"},      done,      e_done);
    chk({tag, "/status"},    status,    e_st);
    chk({tag, "/cycles"},    cycles,    e_cyc);
  endtask

  // Expected outcome straight from the run rules applied to the stimulus arrays
  task automatic model(output int e_end, output logic [1:0] e_st);
    int r = 0;
    e_end = TIMEOUT;
    e_st  = 2'b10;
    for (int i = 1; i <= TIMEOUT; i++) begin
      r = (i > 1 && pcv[i] == pcv[i-1]) ? r + 1 : 0;
      if (hv[i])              begin e_end = i; e_st = 2'b01; return; end
      if (r >= STALL_LIMIT)   begin e_end = i; e_st = 2'b11; return; end
    end
  endtask

  // 0 halt, 1 stall at 0x0010, 2 timeout, 3 halt coinciding with stall, 4 random
  task automatic gen(input int mode, input int base, input int hidx);
    for (int i = 1; i <= TIMEOUT; i++) begin
      hv[i] = 1'b0;
      case (mode)
        1, 3:    pcv[i] = PC_W'((base + i - 1 > 16) ? 16 : base + i - 1);
        4:       pcv[i] = PC_W'($urandom_range(0, 2));
        default: pcv[i] = PC_W'(base + i - 1);
      endcase
      if (mode == 4) hv[i] = ($urandom_range(0, 15) == 0);
    end
    if (mode == 0) hv[hidx] = 1'b1;
    if (mode == 3) hv[17 - base + STALL_LIMIT] = 1'b1;
  endtask

  task automatic do_run(input string nm);
    int e_end;
    logic [1:0] e_st;
    model(e_end, e_st);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out({nm, "/start"}, 0, 0, 0, 2'b00, 0);
`ifdef CPU_RUN_MONITOR_HALT_PC_EN
    chk({nm, "/halt_pc_clr"}, halt_pc, 0);
`endif
    for (int k = 0; k < RST_CYCLES; k++) begin
      start = ($urandom_range(0, 3) == 0);
      pc    = PC_W'($urandom);
      hlt   = 1'($urandom);
      tick();
      chk({nm, "/rst_seq"}, cpu_rst_n, (k == RST_CYCLES - 1));
    end
    for (int i = 1; i <= e_end; i++) begin
      pc    = pcv[i];
      hlt   = hv[i];
      start = ($urandom_range(0, 3) == 0);
      tick();
      if (i < e_end)          chk_out({nm, "/run"}, 1, 1, 0, 2'b00, i);
      else if (e_st == 2'b01) chk_out({nm, "/drain"}, 1, 1, 0, 2'b01, i);
      else                    chk_out({nm, "/end"}, 0, 0, 1, e_st, i);
    end
    if (e_st == 2'b01) begin
      for (int d = 1; d <= DRAIN_CYCLES; d++) begin
        pc    = PC_W'($urandom);
        hlt   = 1'($urandom);
        start = ($urandom_range(0, 1) == 0);
        tick();
        if (d < DRAIN_CYCLES) chk_out({nm, "/drain"}, 1, 1, 0, 2'b01, e_end + d);
        else                  chk_out({nm, "/end"}, 0, 0, 1, 2'b01, e_end + d);
      end
    end
`ifdef CPU_RUN_MONITOR_HALT_PC_EN
    chk({nm, "/halt_pc"}, halt_pc, pcv[e_end]);
`endif
    start = 1'b0;
    for (int h = 0; h < 2; h++) begin
      pc  = PC_W'($urandom);
      hlt = 1'($urandom);
      tick();
      chk_out({nm, "/hold"}, 0, 0, 1, e_st, (e_st == 2'b01) ? e_end + DRAIN_CYCLES : e_end);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; hlt = 1'b0; pc = '0;
    tick();
    tick();
    chk_out("reset", 0, 0, 0, 2'b00, 0);
    rst = 1'b0; start = 1'b0;
    tick();
    chk_out("idle", 0, 0, 0, 2'b00, 0);

    gen(0, 0, 6);  do_run("halt");
    gen(1, 10, 1); do_run("stall");
    gen(2, 0, 1);  do_run("timeout");
    gen(3, 12, 1); do_run("prio");

    // reset mid-run with a simultaneous start
    gen(2, 0, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < RST_CYCLES; k++) tick();
    for (int i = 1; i <= 9; i++) begin
      pc = pcv[i];
      tick();
    end
    chk_out("midrun", 1, 1, 0, 2'b00, 9);
    rst = 1'b1; start = 1'b1;
    tick();
    chk_out("midrun_rst", 0, 0, 0, 2'b00, 0);
    rst = 1'b0; start = 1'b0;
    for (int k = 0; k < RST_CYCLES + 1; k++) tick();
    chk_out("midrun_idle", 0, 0, 0, 2'b00, 0);

    for (int n = 0; n < 30; n++) begin
      int m;
      m = $urandom_range(0, 4);
      gen(m, (m == 1 || m == 3) ? $urandom_range(5, 12) : $urandom_range(0, 200),
          $urandom_range(1, TIMEOUT - 1));
      do_run($sformatf("rnd%0d_m%0d", n, m));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
